// File: rtl/man_mult_arbiter.sv
// man_mult_arbiter: shares one bfloat_man_mult mantissa multiplier between
// NUM_REQ requesters using round-robin arbitration and a two-stage pipeline
// (registered operands -> combinational multiply -> registered result).
// Every result is tagged with the ID of the requester that issued it.
//
// Optional build macro: MAN_ARB_PERF_CNT_EN
//   Defined   -> adds grant_cnt / stall_cnt 32-bit performance counters.
//   Undefined -> the counters and their ports are absent.
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// where valid && ready are both high. A producer holding valid must keep its
// payload stable until the transfer; valid must never depend on ready.
// Here req_ready is combinational from req_valid, so requesters must not
// derive req_valid from req_ready.

// Signed 9x9 mantissa multiplier; keeps the low 16 bits of the product.
module bfloat_man_mult (
  input  logic [8:0]  a,
  input  logic [8:0]  b,
  output logic [15:0] prod
);

  logic signed [17:0] full_prod;

  // Full signed product, then truncate to the 16-bit result width.
  always_comb begin
    full_prod = $signed(a) * $signed(b);
    prod      = full_prod[15:0];
  end

endmodule

module man_mult_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [9*NUM_REQ-1:0] req_a,
  input  logic [9*NUM_REQ-1:0] req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [15:0]          rsp_prod
`ifdef MAN_ARB_PERF_CNT_EN
  ,
  output logic [31:0]          grant_cnt,
  output logic [31:0]          stall_cnt
`endif
);

  // Round-robin pointer: the requester scanned first this cycle.
  logic [ID_W-1:0] rr_ptr;

  // Stage-1 operand registers.
  logic            s1_valid;
  logic [ID_W-1:0] s1_id;
  logic [8:0]      s1_a;
  logic [8:0]      s1_b;

  // Pipeline advance conditions.
  logic s2_adv;
  logic s1_adv;

  // Arbitration results.
  logic               win_found;
  logic [NUM_REQ-1:0] win_oh;
  logic [ID_W-1:0]    win_id;
  logic [ID_W-1:0]    win_next_ptr;
  logic [8:0]         win_a;
  logic [8:0]         win_b;
  logic               grant_fire;
  int                 scan_idx;
  int                 next_idx;

  // Multiplier output, consumed by stage 2.
  logic [15:0] mult_prod;

  bfloat_man_mult u_mult (
    .a    (s1_a),
    .b    (s1_b),
    .prod (mult_prod)
  );

  // Stall chain: the output register frees up when empty or being drained,
  // and stage 1 can take a new pair when empty or moving into stage 2.
  always_comb begin
    s2_adv = !rsp_valid || rsp_ready;
    s1_adv = !s1_valid || s2_adv;
  end

  // Round-robin scan: first asserted req_valid starting from rr_ptr, wrapping
  // modulo NUM_REQ. Also selects that requester's operands and next pointer.
  always_comb begin
    win_found    = 1'b0;
    win_oh       = '0;
    win_id       = '0;
    win_next_ptr = '0;
    win_a        = '0;
    win_b        = '0;
    scan_idx     = 0;
    next_idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = int'(rr_ptr) + k;
      if (scan_idx >= NUM_REQ) begin
        scan_idx = scan_idx - NUM_REQ;
      end
      if (!win_found && (scan_idx < NUM_REQ) && req_valid[scan_idx]) begin
        win_found = 1'b1;
        win_oh[scan_idx] = 1'b1;
        win_id   = ID_W'(scan_idx);
        next_idx = scan_idx + 1;
        if (next_idx >= NUM_REQ) begin
          next_idx = 0;
        end
        win_next_ptr = ID_W'(next_idx);
        win_a = req_a[9*scan_idx +: 9];
        win_b = req_b[9*scan_idx +: 9];
      end
    end
  end

  // Grant only when stage 1 can accept; held low while reset is asserted so
  // req_ready reads zero immediately on an asynchronous reset.
  always_comb begin
    grant_fire = rst_n && s1_adv && win_found;
    req_ready  = grant_fire ? win_oh : '0;
  end

  // Pointer moves just past the requester that was granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (grant_fire) begin
      rr_ptr <= win_next_ptr;
    end
  end

  // Stage 1: capture the winner's operands, or empty out when advancing
  // without a grant; hold while the output register is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_id    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (s1_adv) begin
      s1_valid <= grant_fire;
      if (grant_fire) begin
        s1_id <= win_id;
        s1_a  <= win_a;
        s1_b  <= win_b;
      end
    end
  end

  // Stage 2 (output register): load stage 1 plus the product when free;
  // otherwise hold so the result stays stable under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_prod  <= '0;
    end else if (s2_adv) begin
      rsp_valid <= s1_valid;
      rsp_id    <= s1_id;
      rsp_prod  <= mult_prod;
    end
  end

`ifdef MAN_ARB_PERF_CNT_EN
  // Accepted-request counter, wraps modulo 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt <= '0;
    end else if (grant_fire) begin
      grant_cnt <= grant_cnt + 32'd1;
    end
  end

  // Output-stall cycle counter, wraps modulo 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (rsp_valid && !rsp_ready) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_man_mult_arbiter.sv
// Directed bench for man_mult_arbiter: table-driven single-request vectors,
// then hand-written sequences for round-robin order, backpressure, mid-stream
// reset and (when MAN_ARB_PERF_CNT_EN is defined) the performance counters.
module tb_man_mult_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int W       = ID_W + 16;

  // Clock / reset
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DUT signals
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [9*NUM_REQ-1:0] req_a;
  logic [9*NUM_REQ-1:0] req_b;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic [15:0]          rsp_prod;
`ifdef MAN_ARB_PERF_CNT_EN
  logic [31:0]          grant_cnt;
  logic [31:0]          stall_cnt;
`endif

  man_mult_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_prod  (rsp_prod)
`ifdef MAN_ARB_PERF_CNT_EN
    ,
    .grant_cnt (grant_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  // Scoreboard state
  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    int         idx;
    logic [8:0] a;
    logic [8:0] b;
    logic [15:0] prod;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one cycle; sample/drive 1 time unit after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Every requester presents a = i+1 and the same b.
  task automatic load_slots(input logic [8:0] b_val);
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[9*i +: 9] = 9'(i + 1);
      req_b[9*i +: 9] = b_val;
    end
  endtask

  // Compare a presented result against the scoreboard head.
  task automatic check_rsp(input string name);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      check({name, "_unexpected"}, 32'(rsp_valid), 32'd0);
    end else begin
      e = exp_q.pop_front();
      check({name, "_id"}, 32'(rsp_id), 32'(e[W-1:16]));
      check({name, "_prod"}, 32'(rsp_prod), 32'(e[15:0]));
    end
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NUM_REQ-1:0] exp_rdy;
    logic [W-1:0]       exp_ent;

    vecs[0] = '{idx: 0, a: 9'h080, b: 9'h0C0, prod: 16'h6000};
    vecs[1] = '{idx: 1, a: 9'h1FF, b: 9'h003, prod: 16'hFFFD};
    vecs[2] = '{idx: 2, a: 9'h0FF, b: 9'h0FF, prod: 16'hFE01};
    vecs[3] = '{idx: 3, a: 9'h100, b: 9'h100, prod: 16'h0000};
    vecs[4] = '{idx: 0, a: 9'h100, b: 9'h0FF, prod: 16'h0100};
    vecs[5] = '{idx: 3, a: 9'h1FF, b: 9'h1FF, prod: 16'h0001};
    vecs[6] = '{idx: 1, a: 9'h0FF, b: 9'h001, prod: 16'h00FF};
    vecs[7] = '{idx: 2, a: 9'h1C0, b: 9'h080, prod: 16'hE000};

    // Reset state, checked before any clock edge with everyone requesting.
    rst_n     = 1'b0;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    #3;
    check("reset_req_ready", 32'(req_ready), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_id", 32'(rsp_id), 32'd0);
    check("reset_rsp_prod", 32'(rsp_prod), 32'd0);

    do_reset();

    // Table-driven single-request vectors.
    for (int v = 0; v < 8; v++) begin
      req_a = '0;
      req_b = '0;
      req_a[9*vecs[v].idx +: 9] = vecs[v].a;
      req_b[9*vecs[v].idx +: 9] = vecs[v].b;
      req_valid = '0;
      req_valid[vecs[v].idx] = 1'b1;
      rsp_ready = 1'b1;
      #1;
      exp_rdy = '0;
      exp_rdy[vecs[v].idx] = 1'b1;
      check("vec_req_ready", 32'(req_ready), 32'(exp_rdy));
      tick();
      req_valid = '0;
      check("vec_rsp_early", 32'(rsp_valid), 32'd0);
      tick();
      check("vec_rsp_valid", 32'(rsp_valid), 32'd1);
      check("vec_rsp_id", 32'(rsp_id), 32'(vecs[v].idx));
      check("vec_rsp_prod", 32'(rsp_prod), 32'(vecs[v].prod));
      tick();
      check("vec_rsp_done", 32'(rsp_valid), 32'd0);
    end

    // Round-robin: all four request continuously, results follow 2 behind.
    do_reset();
    load_slots(9'd3);
    req_valid = '1;
    rsp_ready = 1'b1;
    #1;
    for (int c = 0; c < 12; c++) begin
      exp_rdy = '0;
      exp_rdy[c % NUM_REQ] = 1'b1;
      check("rr_grant", 32'(req_ready), 32'(exp_rdy));
      exp_ent = {ID_W'(c % NUM_REQ), 16'(3 * ((c % NUM_REQ) + 1))};
      exp_q.push_back(exp_ent);
      if (c >= 2) check("rr_rsp_valid", 32'(rsp_valid), 32'd1);
      if (rsp_valid) check_rsp("rr_rsp");
      tick();
    end
    req_valid = '0;
    for (int c = 0; c < 4; c++) begin
      if (rsp_valid) check_rsp("rr_drain");
      tick();
    end
    check("rr_all_returned", 32'(exp_q.size()), 32'd0);

    // Backpressure with two results in flight.
    do_reset();
    load_slots(9'd5);
    req_valid = '1;
    rsp_ready = 1'b0;
    #1;
    check("bp_grant0", 32'(req_ready), 32'b0001);
    tick();
    check("bp_grant1", 32'(req_ready), 32'b0010);
    tick();
    for (int k = 0; k < 5; k++) begin
      check("bp_req_ready", 32'(req_ready), 32'd0);
      check("bp_hold_valid", 32'(rsp_valid), 32'd1);
      check("bp_hold_id", 32'(rsp_id), 32'd0);
      check("bp_hold_prod", 32'(rsp_prod), 32'd5);
      tick();
    end
    rsp_ready = 1'b1;
    req_valid = '0;
    #1;
    check("bp_out0_valid", 32'(rsp_valid), 32'd1);
    check("bp_out0_id", 32'(rsp_id), 32'd0);
    check("bp_out0_prod", 32'(rsp_prod), 32'd5);
    tick();
    check("bp_out1_valid", 32'(rsp_valid), 32'd1);
    check("bp_out1_id", 32'(rsp_id), 32'd1);
    check("bp_out1_prod", 32'(rsp_prod), 32'd10);
    tick();
    check("bp_empty", 32'(rsp_valid), 32'd0);

    // Asynchronous reset mid-stream.
    do_reset();
    load_slots(9'd7);
    req_valid = '1;
    rsp_ready = 1'b1;
    repeat (3) tick();
    check("mr_pre_valid", 32'(rsp_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_req_ready", 32'(req_ready), 32'd0);
    check("mr_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mr_rsp_id", 32'(rsp_id), 32'd0);
    check("mr_rsp_prod", 32'(rsp_prod), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mr_first_grant", 32'(req_ready), 32'b0001);
    check("mr_no_stale", 32'(rsp_valid), 32'd0);
    tick();
    check("mr_no_stale2", 32'(rsp_valid), 32'd0);
    tick();
    check("mr_out_valid", 32'(rsp_valid), 32'd1);
    check("mr_out_id", 32'(rsp_id), 32'd0);
    check("mr_out_prod", 32'(rsp_prod), 32'd7);
    req_valid = '0;
    repeat (3) tick();

`ifdef MAN_ARB_PERF_CNT_EN
    // Performance counters: 10 grants, then 3 stalled cycles.
    do_reset();
    load_slots(9'd2);
    req_valid = '1;
    rsp_ready = 1'b1;
    repeat (10) tick();
    req_valid = '0;
    rsp_ready = 1'b0;
    repeat (3) tick();
    check("perf_grant_cnt", grant_cnt, 32'd10);
    check("perf_stall_cnt", stall_cnt, 32'd3);
    rsp_ready = 1'b1;
    repeat (3) tick();
    check("perf_stall_final", stall_cnt, 32'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
